rr_grant_fifo: RTL and testbench
================================

# rr_grant_fifo

Downstream stage of the round-robin arbiter. It consumes the arbiter's registered `grant`/`grant_id` pair and captures the granted client's payload. The captured words, tagged with the client ID, go into an in-order FIFO that drains over a valid/ready interface. It also returns a one-cycle acknowledge to the granted client and gives the upstream logic an early-warning level so request injection can be throttled. The arbiter itself has no backpressure.

## Interface
- `N`, 8, number of clients; must match the arbiter; power of 2, ≥2
- `DW`, 32, payload width per client
- `DEPTH`, 4, FIFO entries; power of 2, ≥4
- `AF_LEVEL`, DEPTH-2, occupancy at or above which `almost_full` asserts
- `clk` input 1 — single clock, rising edge
- `reset_b` input 1 — reset, asynchronous, active-low
- `grant` input 1 — arbiter grant strobe, one cycle per serviced request
- `grant_id` input $clog2(N) — index of granted client; valid only when `grant`=1
- `req_data` input N*DW — client payloads, client k at bits [k*DW +: DW]
- `ack` output N — one-hot, one-cycle acknowledge to the granted client
- `out_valid` output 1 — head entry available
- `out_ready` input 1 — consumer accepts head entry
- `out_data` output DW — head payload
- `out_id` output $clog2(N) — head client ID
- `count` output $clog2(DEPTH)+1 — current occupancy, 0..DEPTH
- `almost_full` output 1 — `count` ≥ AF_LEVEL
- `overflow` output 1 — sticky: a grant arrived and could not be stored

## Operation
- Push: on an edge where `grant`=1, write {grant_id, req_data[grant_id*DW +: DW]} at the write pointer if space is available.
  - Space is available when `count`<DEPTH, or when `count`=DEPTH and a pop occurs on the same edge.
- Pop: on an edge where `out_valid`=1 and `out_ready`=1, advance the read pointer.
- Pointer and count arithmetic:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - `count` is updated as +1 for push only, −1 for pop only, and unchanged for both or neither.
- Data path:
  - The FIFO is show-ahead: `out_data`/`out_id` are driven from storage at the read pointer.
  - `out_valid` = (`count`≠0).
- Flow control:
  - Pop when empty is impossible because `out_valid`=0.
  - `out_ready` while `out_valid`=0 is ignored.
- Drop on full:
  - A grant that arrives when full with no simultaneous pop is dropped: no write, no `ack`.
  - The drop sets `overflow`=1, which holds until reset.
- Acknowledge:
  - `ack` is registered. Bit `grant_id` pulses for exactly one cycle after each accepted push.
  - All other `ack` bits are 0.
- `grant_id` is ignored when `grant`=0. An out-of-range `grant_id` cannot occur when N is a power of 2.
- Reset (asynchronous, active-low):
  - Clears pointers, `count`, `ack`, `almost_full` and `overflow`; `out_valid`=0.
  - Storage contents are don't-care after reset. `out_data`/`out_id` are don't-care while `out_valid`=0.
  - Reset mid-operation discards all entries. Any `ack` in flight is cleared on the same cycle reset asserts.

## Timing
- Grant latency: `grant` high in cycle t, push at the end of t.
  - `ack[grant_id]` is high in cycle t+1.
  - `count` reflects the push in t+1.
  - If the FIFO was empty, `out_valid`=1 with that entry at the head in t+1.
- Pop: entry leaves at the edge where valid & ready. The next entry, or `out_valid`=0, is visible in the following cycle.
- Throughput: one push and one pop per cycle, sustained. Simultaneous push+pop at any occupancy, including full, keeps `count` constant.
- `almost_full` and `overflow` are registered, so both update one cycle after the causing edge.
- Headroom rule: `almost_full` at DEPTH-2 leaves two cycles of grant headroom. This matches the arbiter's registered grant plus one cycle of upstream reaction.
- Ordering: entries pop strictly in grant order. No reordering, no bypass of stored entries.

## Test plan
- Single grant, DEPTH=4 (empty FIFO, `grant`=1, `grant_id`=3, client 3 data 0xA5A5_0003 in cycle t):
  - `ack`=8'b0000_1000 in t+1 only.
  - `out_valid`=1, `out_id`=3, `out_data`=0xA5A5_0003, `count`=1 in t+1.
  - With `out_ready`=1 in t+1, `count`=0 and `out_valid`=0 in t+2.
- Fill and overflow (`out_ready`=0, grants to IDs 0,1,2,3,4 on consecutive cycles):
  - `almost_full`=1 after the 2nd push; `count`=4 after the 4th push.
  - The 5th grant gives no `ack`, `overflow`=1 next cycle and sticky.
  - Draining then yields IDs 0,1,2,3 in order.
- Full with simultaneous push/pop (`count`=4, `out_ready`=1, `grant`=1 `grant_id`=5):
  - Push accepted, `ack[5]` pulses.
  - `count` stays 4, `overflow` stays 0.
  - ID 5 pops 4th after the current head.
- Streaming (grants every cycle cycling IDs 0..7, `out_ready`=1 continuously):
  - `count` settles at 1.
  - The output stream is IDs 0..7 repeating with no gaps.
  - `almost_full` never asserts.
- Wrap-around (push/pop 3×DEPTH+1 entries with random `out_ready`):
  - Every payload is received exactly once, in order.
  - `count` never exceeds DEPTH.
- Reset mid-operation (`count`=3, `ack` pulse pending; assert `reset_b`=0 asynchronously between edges):
  - `ack`=0, `out_valid`=0, `count`=0 and `overflow`=0 immediately.
  - After release, the first grant behaves as in the single-grant test.

Source files
------------

// File: rtl/rr_grant_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_fifo
// Description : Captures the round-robin arbiter's granted payload into an
//               in-order show-ahead FIFO, acknowledges the client, and flags
//               almost-full / sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_fifo #(
    parameter int N        = 8,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       grant,
    input  logic [$clog2(N)-1:0]       grant_id,
    input  logic [N*DW-1:0]            req_data,
    output logic [N-1:0]               ack,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [$clog2(N)-1:0]       out_id,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_IW = $clog2(N);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF    = c_CW'(AF_LEVEL);

    logic [DW-1:0]    r_mem_data [DEPTH];
    logic [c_IW-1:0]  r_mem_id   [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_almost_full;
    logic             r_overflow;
    logic [N-1:0]     r_ack;

    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [DW-1:0]    w_grant_data;
    logic [c_CW-1:0]  w_count_next;
    logic [N-1:0]     w_ack_next;

    assign w_pop        = (r_count != '0) && out_ready;
    assign w_full       = (r_count == c_DEPTH);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push       = grant && (!w_full || w_pop);
    assign w_drop       = grant && w_full && !w_pop;
    assign w_grant_data = req_data[grant_id*DW +: DW];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CW'(1);
            2'b01:   w_count_next = r_count - c_CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    for (genvar k = 0; k < N; k++) begin : g_ack_dec
        assign w_ack_next[k] = w_push && (grant_id == c_IW'(k));
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_ack         <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= c_AF);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_ack <= w_ack_next;
        end
    end

    // Storage needs no reset: contents are only observed while out_valid=1.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_grant_data;
            r_mem_id[r_wr_ptr]   <= grant_id;
        end
    end

    assign ack         = r_ack;
    assign out_valid   = (r_count != '0);
    assign out_data    = r_mem_data[r_rd_ptr];
    assign out_id      = r_mem_id[r_rd_ptr];
    assign count       = r_count;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_fifo
// Description : Self-checking bench for rr_grant_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_fifo;

    localparam int N        = 8;
    localparam int DW       = 32;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int IW       = 3;
    localparam int CW       = 3;

    logic            clk       = 1'b0;
    logic            reset_b   = 1'b0;
    logic            grant     = 1'b0;
    logic [IW-1:0]   grant_id  = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic            out_ready = 1'b0;
    logic [N-1:0]    ack;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic [CW-1:0]   count;
    logic            almost_full;
    logic            overflow;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } entry_t;

    entry_t       q[$];
    bit           m_ovf = 1'b0;
    logic [N-1:0] m_ack = '0;
    int           checks = 0;
    int           errors = 0;
    int           max_seen = 0;

    rr_grant_fifo #(.N(N), .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .grant       (grant),
        .grant_id    (grant_id),
        .req_data    (req_data),
        .ack         (ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("count",       64'(count),       64'(q.size()));
        chk("out_valid",   64'(out_valid),   64'(q.size() != 0));
        chk("almost_full", 64'(almost_full), 64'(q.size() >= AF_LEVEL));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("ack",         64'(ack),         64'(m_ack));
        if (q.size() != 0) begin
            chk("out_id",   64'(out_id),   64'(q[0].id));
            chk("out_data", 64'(out_data), 64'(q[0].data));
        end
        if (int'(count) > max_seen) max_seen = int'(count);
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = $urandom();
    endtask

    // Called at a falling edge; applies inputs, predicts the rising edge, checks at the next falling edge.
    task automatic cycle(input bit g, input int id, input bit rdy);
        bit     pop;
        bit     push;
        entry_t e;
        grant     = g;
        grant_id  = IW'(id);
        out_ready = rdy;
        pop  = (q.size() != 0) && rdy;
        push = g && ((q.size() < DEPTH) || pop);
        e.id   = IW'(id);
        e.data = req_data[id*DW +: DW];
        m_ack = '0;
        if (push) m_ack[id] = 1'b1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        if (g && !push) m_ovf = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (q.size() != 0) begin
                rand_data();
                cycle(1'b0, int'($urandom_range(0, N-1)), 1'b1);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        check_state();
        reset_b = 1'b1;
        @(negedge clk);
        check_state();

        // Single grant to client 3
        rand_data();
        req_data[3*DW +: DW] = 32'hA5A5_0003;
        cycle(1'b1, 3, 1'b0);
        chk("single_ack", 64'(ack), 64'h08);
        chk("single_data", 64'(out_data), 64'hA5A5_0003);
        cycle(1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) begin
            rand_data();
            cycle(1'b1, i, 1'b0);
        end
        rand_data();
        cycle(1'b1, 5, 1'b1);
        chk("full_pp_ack5", 64'(ack), 64'h20);
        drain();

        // Streaming
        for (int i = 0; i < 32; i++) begin
            rand_data();
            cycle(1'b1, i % N, 1'b1);
        end
        chk("stream_count", 64'(count), 64'd1);
        drain();

        // Random wrap-around traffic
        max_seen = 0;
        for (int i = 0; i < 200; i++) begin
            rand_data();
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, N-1)), bit'($urandom_range(0, 1)));
        end
        drain();
        chk("max_count_le_depth", 64'(max_seen <= DEPTH), 64'd1);

        // Fill and overflow
        for (int i = 0; i < 5; i++) begin
            rand_data();
            cycle(1'b1, i, 1'b0);
        end
        chk("ovf_no_ack", 64'(ack), 64'h0);
        cycle(1'b0, 0, 1'b0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        drain();

        // Reset mid-operation with an ack pending
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle(1'b1, i + 2, 1'b0);
        end
        #2 reset_b = 1'b0;
        #1;
        chk("rst_ack",       64'(ack),       64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_count",     64'(count),     64'h0);
        chk("rst_overflow",  64'(overflow),  64'h0);
        q.delete();
        m_ovf = 1'b0;
        m_ack = '0;
        grant = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        check_state();

        rand_data();
        req_data[3*DW +: DW] = 32'hA5A5_0003;
        cycle(1'b1, 3, 1'b0);
        chk("post_rst_ack", 64'(ack), 64'h08);
        cycle(1'b0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
